// File: rtl/pc_sequencer_if.sv
// Run-control and PC bus of the pc_sequencer stage.
// The master side drives the run-control flags and the next-PC selection; the slave side returns the PC, the run status and the retired-instruction count.
interface pc_sequencer_if #(
   parameter int unsigned data_width = 16
);
   logic                  start;
   logic                  halt;
   logic                  stall;
   logic [data_width-1:0] next_pc;
   logic [data_width-1:0] pc_out;
   logic [data_width-1:0] pc_plus1;
   logic                  running;
   logic                  done;
   logic [15:0]           instr_count;

   modport master (
      output start, halt, stall, next_pc,
      input  pc_out, pc_plus1, running, done, instr_count
   );

   modport slave (
      input  start, halt, stall, next_pc,
      output pc_out, pc_plus1, running, done, instr_count
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the PC, advances it under idle/run/halted control,
// supplies PC+1 to the next-PC mux and counts retired instructions (saturating).
module pc_sequencer #(
   parameter int unsigned          data_width = 16,
   parameter logic [data_width-1:0] start_addr = '0
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [data_width-1:0] pc_q, pc_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [15:0]           cnt_inc;

   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= start_addr;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            pc_d = start_addr;
            if (bus.start) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            // HALT retires and wins over stall; the PC stays on the HALT address.
            if (bus.halt) begin
               state_d = HALTED;
               cnt_d   = cnt_inc;
            end else if (!bus.stall) begin
               pc_d  = bus.next_pc;
               cnt_d = cnt_inc;
            end
         end
         HALTED: begin
            if (bus.start) begin
               state_d = RUN;
               pc_d    = start_addr;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = start_addr;
         end
      endcase
   end

   assign bus.pc_out      = pc_q;
   assign bus.pc_plus1    = pc_q + data_width'(1);
   assign bus.running     = (state_q == RUN);
   assign bus.done        = (state_q == HALTED);
   assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a driver updates a behavioural model and queues the expected
// outputs each cycle; an independent monitor pops and compares after every rising edge.
module tb_pc_sequencer;

   localparam logic [15:0] START = 16'h0000;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] pp1;
      logic        run;
      logic        dn;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   pc_sequencer_if #(.data_width(16)) bus ();

   pc_sequencer #(
      .data_width(16),
      .start_addr(START)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cycle  = 0;

   int          m_mode = M_IDLE;
   logic [15:0] m_pc   = START;
   int          m_cnt  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cycle, act, exp);
      end
   endtask

   function automatic int sat_inc(input int c);
      return (c >= 65535) ? 65535 : c + 1;
   endfunction

   task automatic step(input bit rst, input bit st, input bit hl, input bit sl,
                       input logic [15:0] np);
      exp_t e;
      @(negedge clk);
      reset       = rst;
      bus.start   = st;
      bus.halt    = hl;
      bus.stall   = sl;
      bus.next_pc = np;
      if (rst) begin
         m_mode = M_IDLE;
         m_pc   = START;
         m_cnt  = 0;
      end else begin
         case (m_mode)
            M_IDLE: if (st) begin
               m_mode = M_RUN;
               m_cnt  = 0;
            end
            M_RUN: if (hl) begin
               m_mode = M_HALT;
               m_cnt  = sat_inc(m_cnt);
            end else if (!sl) begin
               m_pc  = np;
               m_cnt = sat_inc(m_cnt);
            end
            default: if (st) begin
               m_mode = M_RUN;
               m_pc   = START;
               m_cnt  = 0;
            end
         endcase
      end
      e.pc  = m_pc;
      e.pp1 = m_pc + 16'd1;
      e.run = (m_mode == M_RUN);
      e.dn  = (m_mode == M_HALT);
      e.cnt = m_cnt[15:0];
      sb.push_back(e);
   endtask

   // Monitor: compares the DUT against the queued expectation after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc_out",      32'(bus.pc_out),      32'(e.pc));
            chk("pc_plus1",    32'(bus.pc_plus1),    32'(e.pp1));
            chk("running",     32'(bus.running),     32'(e.run));
            chk("done",        32'(bus.done),        32'(e.dn));
            chk("instr_count", 32'(bus.instr_count), 32'(e.cnt));
         end
      end
   end

   initial begin
      bus.start   = 1'b1;
      bus.halt    = 1'b0;
      bus.stall   = 1'b0;
      bus.next_pc = '0;

      // Reset with start high, then idle with noise on the ignored inputs.
      repeat (2) step(1, 1, 0, 0, 16'h0000);
      for (int i = 0; i < 5; i++) step(0, 0, i[0], i[1], 16'h1234);

      // Sequential run.
      step(0, 1, 0, 0, 16'h5555);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, m_pc + 16'd1);

      // Branch then stall.
      step(0, 0, 0, 0, 16'h0040);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'h0099);
      step(0, 0, 0, 0, 16'h0041);

      // Halt together with stall, then halted ignores halt/next_pc.
      step(0, 0, 1, 1, 16'h0077);
      for (int i = 0; i < 3; i++) step(0, 0, i[0], 0, 16'hBEEF);

      // Restart with start held over several cycles.
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, m_pc + 16'd1);

      // Long run into counter saturation.
      while (m_cnt < 65534) step(0, 0, 0, 0, m_pc + 16'd1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, m_pc + 16'd1);

      // PC wrap at the top of the address space.
      step(0, 0, 0, 0, 16'hFFFF);
      for (int i = 0; i < 2; i++) step(0, 0, 0, 0, m_pc + 16'd1);

      // Reset mid-run with everything else asserted.
      step(1, 1, 1, 1, 16'h2222);
      step(0, 0, 0, 0, 16'h3333);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         bit          r, s, h, t;
         logic [15:0] np;
         r  = ($urandom_range(0, 59) == 0);
         s  = ($urandom_range(0, 3) == 0);
         h  = ($urandom_range(0, 7) == 0);
         t  = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       np = 16'($urandom);
            1:       np = 16'hFFFE + 16'($urandom_range(0, 1));
            default: np = m_pc + 16'd1;
         endcase
         step(r, s, h, t, np);
      end

      repeat (2) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
